ps2_ascii_decoder: RTL and testbench

PS2_ASCII_DECODER -- requirements
Module: ps2_ascii_decoder

---
 rtl/ps2_ascii_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 keyboard receiver: frames ps2_clk/ps2_data, tracks make/break/extended prefixes, outputs held key as ASCII.
// Latency: outputs register 3 clk cycles after the stop-bit falling edge at the pin (2 sync stages + 1 output stage).
// Backpressure: none; the keyboard cannot be stalled, so key_valid/frame_err are fire-and-forget pulses.
module ps2_ascii_decoder #(
    parameter logic [7:0]  IDLE_CODE      = 8'h31,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } state_e;

    logic [1:0]    rst_sync_q, rst_sync_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    state_e        state_q, state_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    held_q, held_d;
    logic [7:0]    ascii_q, ascii_d;
    logic [7:0]    scan_q, scan_d;
    logic          key_valid_q, key_valid_d;
    logic          frame_err_q, frame_err_d;

    logic          run;
    logic          fall;
    logic          byte_ok;
    logic [7:0]    rx_byte;
    logic [8:0]    map_res;

    // Returns {mapped, ascii}.
    function automatic logic [8:0] map_key(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h41};
            8'h32: r = {1'b1, 8'h42};
            8'h21: r = {1'b1, 8'h43};
            8'h23: r = {1'b1, 8'h44};
            8'h24: r = {1'b1, 8'h45};
            8'h2B: r = {1'b1, 8'h46};
            8'h34: r = {1'b1, 8'h47};
            8'h33: r = {1'b1, 8'h48};
            8'h43: r = {1'b1, 8'h49};
            8'h3B: r = {1'b1, 8'h4A};
            8'h42: r = {1'b1, 8'h4B};
            8'h4B: r = {1'b1, 8'h4C};
            8'h3A: r = {1'b1, 8'h4D};
            8'h31: r = {1'b1, 8'h4E};
            8'h44: r = {1'b1, 8'h4F};
            8'h4D: r = {1'b1, 8'h50};
            8'h15: r = {1'b1, 8'h51};
            8'h2D: r = {1'b1, 8'h52};
            8'h1B: r = {1'b1, 8'h53};
            8'h2C: r = {1'b1, 8'h54};
            8'h3C: r = {1'b1, 8'h55};
            8'h2A: r = {1'b1, 8'h56};
            8'h1D: r = {1'b1, 8'h57};
            8'h22: r = {1'b1, 8'h58};
            8'h35: r = {1'b1, 8'h59};
            8'h1A: r = {1'b1, 8'h5A};
            8'h5A: r = {1'b1, 8'h0D};
            8'h29: r = {1'b1, 8'h20};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        tmo_cnt_d   = tmo_cnt_q;
        state_d     = state_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        held_d      = held_q;
        ascii_d     = ascii_q;
        scan_d      = scan_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        byte_ok     = 1'b0;

        run     = rst_sync_q[1];
        fall    = clk_prev_q & ~clk_sync_q[1];
        rx_byte = frame_q[8:1];
        map_res = map_key(rx_byte);

        // frame_q holds start in [0], data in [8:1], parity in [9] once 10 bits are in.
        if (fall) begin
            tmo_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!frame_q[0] && dat_sync_q[1] && (^frame_q[9:1])) begin
                    byte_ok = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                frame_d   = {dat_sync_q[1], frame_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_cnt_q == TMO_LAST) begin
                bit_cnt_d = 4'd0;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        if (byte_ok) begin
            scan_d = rx_byte;
            if (rx_byte == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                if (state_q == ST_HELD && rx_byte == held_q) begin
                    ascii_d = IDLE_CODE;
                    state_d = ST_IDLE;
                end
                brk_d = 1'b0;
            end else begin
                key_valid_d = 1'b1;
                if (map_res[8]) begin
                    ascii_d = map_res[7:0];
                    held_d  = rx_byte;
                    state_d = ST_HELD;
                end
            end
        end

        // Hold everything in reset until the deassertion has crossed into clk.
        if (!run) begin
            clk_sync_d  = 2'b11;
            dat_sync_d  = 2'b11;
            clk_prev_d  = 1'b1;
            bit_cnt_d   = 4'd0;
            frame_d     = '0;
            tmo_cnt_d   = '0;
            state_d     = ST_IDLE;
            brk_d       = 1'b0;
            ext_d       = 1'b0;
            held_d      = 8'h00;
            ascii_d     = IDLE_CODE;
            scan_d      = 8'h00;
            key_valid_d = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q  <= 2'b00;
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= 4'd0;
            frame_q     <= '0;
            tmo_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            held_q      <= 8'h00;
            ascii_q     <= IDLE_CODE;
            scan_q      <= 8'h00;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            tmo_cnt_q   <= tmo_cnt_d;
            state_q     <= state_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            held_q      <= held_d;
            ascii_q     <= ascii_d;
            scan_q      <= scan_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ascii     = ascii_q;
    assign scan_code = scan_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Scoreboard bench for ps2_ascii_decoder: directed keyboard scenarios followed by random frames,
// with a monitor that matches every key_valid/frame_err pulse against queued expectations.
module tb_ps2_ascii_decoder;

    localparam int         TMO  = 200;
    localparam logic [7:0] IDLE = 8'h31;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii;
    logic [7:0] scan_code;
    logic       key_valid;
    logic       frame_err;

    ps2_ascii_decoder #(
        .IDLE_CODE     (IDLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ascii    (ascii),
        .scan_code(scan_code),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] scan;
        logic [7:0] asc;
        time        t_stop;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  kv_count = 0;
    int  fe_count = 0;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] kmap [logic [7:0]];

    // Keyboard-level reference state.
    logic [7:0] m_ascii;
    logic [7:0] m_scan;
    logic [7:0] m_held;
    bit         m_has_held;
    bit         m_brk;
    bit         m_ext;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ascii    = IDLE;
        m_scan     = 8'h00;
        m_held     = 8'h00;
        m_has_held = 0;
        m_brk      = 0;
        m_ext      = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input time t);
        ev_t e;
        m_scan = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_ext) begin
            m_ext = 0;
            m_brk = 0;
        end else if (m_brk) begin
            if (m_has_held && b == m_held) begin
                m_ascii    = IDLE;
                m_has_held = 0;
            end
            m_brk = 0;
        end else begin
            if (kmap.exists(b)) begin
                m_ascii    = kmap[b];
                m_held     = b;
                m_has_held = 1;
            end
            e.is_err = 0; e.scan = m_scan; e.asc = m_ascii; e.t_stop = t;
            exp_q.push_back(e);
        end
    endtask

    // err: 0 good, 1 bad parity, 2 bad start, 3 bad stop
    task automatic send_frame(input logic [7:0] b, input int err);
        logic [10:0] f;
        ev_t e;
        f[0]   = (err == 2);
        f[8:1] = b;
        f[9]   = (~^b) ^ (err == 1);
        f[10]  = (err != 3);
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            #40;
            if (i == 10) begin
                if (err != 0) begin
                    e.is_err = 1; e.scan = m_scan; e.asc = m_ascii; e.t_stop = $time;
                    exp_q.push_back(e);
                end else begin
                    model_byte(b, $time);
                end
            end
            ps2_clk = 1'b0;
            #80;
            ps2_clk = 1'b1;
            #40;
        end
        ps2_data = 1'b1;
        check("ascii_after_frame", ascii, m_ascii);
        check("scan_after_frame", scan_code, m_scan);
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'(i & 1);
            #40;
            ps2_clk = 1'b0;
            #80;
            ps2_clk = 1'b1;
            #40;
        end
        ps2_data = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid && frame_err) begin
                n_cmp++; n_bad++;
                $display("FAIL pulse_overlap: key_valid=1 frame_err=1 required not both at %0t", $time);
            end
            if (key_valid) kv_count++;
            if (frame_err) fe_count++;
            if (key_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_pulse: kv=%0b fe=%0b scan=%0h required no pulse at %0t",
                             key_valid, frame_err, scan_code, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_is_err", 32'(frame_err), 32'(mon_e.is_err));
                    check("pulse_scan", scan_code, mon_e.scan);
                    check("pulse_ascii", ascii, mon_e.asc);
                    check("pulse_latency_ok", 32'(($time - mon_e.t_stop) <= 45), 32'd1);
                end
            end
            if (exp_q.size() > 0 && ($time - exp_q[0].t_stop) > 60) begin
                mon_e = exp_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missing_pulse: no pulse within window, required scan=%0h err=%0b", mon_e.scan, mon_e.is_err);
            end
        end
    end

    initial begin
        int kv0;
        int fe0;
        int r;
        int ek;
        logic [7:0] b;

        for (int i = 0; i < 26; i++) kmap[letter_codes[i]] = 8'h41 + 8'(i);
        kmap[8'h5A] = 8'h0D;
        kmap[8'h29] = 8'h20;
        model_reset();

        #23;
        check("rst_ascii", ascii, IDLE);
        check("rst_scan", scan_code, 8'h00);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        #50 rst_n = 1'b1;
        #100;

        kv0 = kv_count;
        send_frame(8'h1C, 0);
        check("make_A_ascii", ascii, 8'h41);
        check("make_A_kv_count", kv_count - kv0, 1);

        kv0 = kv_count;
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check("break_A_ascii", ascii, IDLE);
        check("break_A_kv_count", kv_count - kv0, 1);

        kv0 = kv_count;
        send_frame(8'h5A, 0);
        check("enter_ascii", ascii, 8'h0D);
        send_frame(8'h1C, 0);
        send_frame(8'h1C, 0);
        send_frame(8'h1C, 0);
        check("typematic_ascii", ascii, 8'h41);
        check("typematic_kv_count", kv_count - kv0, 4);

        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        fe0 = fe_count;
        send_frame(8'h1C, 1);
        check("parity_ascii", ascii, IDLE);
        check("parity_scan", scan_code, 8'h1C);
        check("parity_fe_count", fe_count - fe0, 1);

        fe0 = fe_count;
        send_partial(6);
        #((TMO + 10) * 10);
        send_frame(8'h29, 0);
        check("timeout_space_ascii", ascii, 8'h20);
        check("timeout_fe_count", fe_count - fe0, 0);

        kv0 = kv_count;
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        check("ext_ascii", ascii, 8'h20);
        check("ext_kv_count", kv_count - kv0, 0);

        send_partial(5);
        rst_n = 1'b0;
        model_reset();
        #30;
        check("midrst_ascii", ascii, IDLE);
        check("midrst_scan", scan_code, 8'h00);
        #50 rst_n = 1'b1;
        #100;
        send_frame(8'h32, 0);
        check("post_rst_B_ascii", ascii, 8'h42);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                ek = $urandom_range(0, 27);
                b  = (ek < 26) ? letter_codes[ek] : ((ek == 26) ? 8'h5A : 8'h29);
            end else if (r == 5) b = 8'hF0;
            else if (r == 6) b = 8'hE0;
            else if (r == 7) b = m_held;
            else b = 8'($urandom);
            ek = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            send_frame(b, ek);
            #($urandom_range(0, 20) * 10);
        end

        #200;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
